// File: rtl/dbsao_lcu_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : dbsao_lcu_scheduler
//  Description : Frame-level initiator for the deblocking/SAO engine. Walks
//                the picture in LCU raster order and issues one start pulse
//                per LCU. It waits for the engine's done pulse under a
//                watchdog, then reports frame completion or a sticky timeout.
//  Revision    : 1.0 - initial release
// ============================================================================
module dbsao_lcu_scheduler #(
  parameter int LCU_W_BITS = 7,
  parameter int LCU_H_BITS = 7,
  parameter int TO_BITS    = 11,
  parameter int TIMEOUT    = 1500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  frame_start_i,
  input  logic [LCU_W_BITS-1:0] pic_w_lcu_i,
  input  logic [LCU_H_BITS-1:0] pic_h_lcu_i,
  input  logic                  lcu_ready_i,
  input  logic                  dbsao_done_i,
  output logic                  dbsao_start_o,
  output logic [LCU_W_BITS-1:0] lcu_x_o,
  output logic [LCU_H_BITS-1:0] lcu_y_o,
  output logic                  busy_o,
  output logic                  frame_done_o,
  output logic                  timeout_o
);

  // Last watchdog value allowed in RUN; reaching it without done means error.
  localparam logic [TO_BITS-1:0] C_WD_LAST = TO_BITS'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_WAIT  = 3'd1,
    S_START = 3'd2,
    S_RUN   = 3'd3,
    S_NEXT  = 3'd4,
    S_DONE  = 3'd5,
    S_ERR   = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [LCU_W_BITS-1:0] w_q, w_d;
  logic [LCU_H_BITS-1:0] h_q, h_d;
  logic [LCU_W_BITS-1:0] x_q, x_d;
  logic [LCU_H_BITS-1:0] y_q, y_d;
  logic [TO_BITS-1:0]    wd_q, wd_d;
  logic                  timeout_q, timeout_d;

  logic                  w_last_col;
  logic                  w_last_row;

  // Position of the current LCU relative to the latched frame dimensions.
  assign w_last_col = (x_q == (w_q - LCU_W_BITS'(1)));
  assign w_last_row = (y_q == (h_q - LCU_H_BITS'(1)));

  // State register, counters and latched dimensions; async active-low reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      w_q       <= '0;
      h_q       <= '0;
      x_q       <= '0;
      y_q       <= '0;
      wd_q      <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      w_q       <= w_d;
      h_q       <= h_d;
      x_q       <= x_d;
      y_q       <= y_d;
      wd_q      <= wd_d;
      timeout_q <= timeout_d;
    end
  end

  // Next-state logic: frame walk, watchdog and error handling.
  always_comb begin
    state_d   = state_q;
    w_d       = w_q;
    h_d       = h_q;
    x_d       = x_q;
    y_d       = y_q;
    wd_d      = wd_q;
    timeout_d = timeout_q;

    unique case (state_q)
      S_IDLE: begin
        if (frame_start_i) begin
          state_d   = S_WAIT;
          // A zero dimension would never terminate the walk; treat it as 1.
          w_d       = (pic_w_lcu_i == '0) ? LCU_W_BITS'(1) : pic_w_lcu_i;
          h_d       = (pic_h_lcu_i == '0) ? LCU_H_BITS'(1) : pic_h_lcu_i;
          x_d       = '0;
          y_d       = '0;
          timeout_d = 1'b0;
        end
      end

      S_WAIT: begin
        if (lcu_ready_i) begin
          state_d = S_START;
        end
      end

      S_START: begin
        wd_d    = '0;
        state_d = S_RUN;
      end

      S_RUN: begin
        // Done takes priority over an expiring watchdog in the same cycle.
        if (dbsao_done_i) begin
          state_d = S_NEXT;
        end else if (wd_q == C_WD_LAST) begin
          state_d = S_ERR;
        end else begin
          wd_d = wd_q + TO_BITS'(1);
        end
      end

      S_NEXT: begin
        if (w_last_col && w_last_row) begin
          state_d = S_DONE;
        end else if (w_last_col) begin
          x_d     = '0;
          y_d     = y_q + LCU_H_BITS'(1);
          state_d = S_WAIT;
        end else begin
          x_d     = x_q + LCU_W_BITS'(1);
          state_d = S_WAIT;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      S_ERR: begin
        timeout_d = 1'b1;
        state_d   = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only, no input feed-through.
  assign dbsao_start_o = (state_q == S_START);
  assign frame_done_o  = (state_q == S_DONE);
  assign busy_o        = (state_q != S_IDLE);
  assign lcu_x_o       = x_q;
  assign lcu_y_o       = y_q;
  assign timeout_o     = timeout_q;

endmodule
`default_nettype wire

// File: tb/tb_dbsao_lcu_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_dbsao_lcu_scheduler
//  Description : Scoreboard bench for dbsao_lcu_scheduler. Stimulus pushes
//                the expected event list of each frame; a negedge monitor
//                pops and compares events and checks cycle timing.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_dbsao_lcu_scheduler;

  localparam int TIMEOUT = 1500;
  localparam int K_START = 0;
  localparam int K_FDONE = 1;
  localparam int K_TOUT  = 2;

  typedef struct {
    int kind;
    int x;
    int y;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_start_i = 1'b0;
  logic [6:0] pic_w_lcu_i = '0;
  logic [6:0] pic_h_lcu_i = '0;
  logic       lcu_ready_i = 1'b0;
  logic       dbsao_done_i;
  logic       dbsao_start_o;
  logic [6:0] lcu_x_o;
  logic [6:0] lcu_y_o;
  logic       busy_o;
  logic       frame_done_o;
  logic       timeout_o;

  logic eng_done = 1'b0;
  logic stray_done = 1'b0;
  assign dbsao_done_i = eng_done | stray_done;

  int  eng_delay = 5;
  bit  eng_never = 1'b0;
  int  eng_cnt = 0;
  int  rdy_mode = 0;
  bit  rdy_val = 1'b1;

  int  cyc = 0;
  int  n_chk = 0;
  int  n_pass = 0;
  int  n_starts = 0;
  int  n_dones = 0;
  ev_t exp_q[$];

  // monitor model state
  bit  m_busy = 1'b0;
  bit  m_to = 1'b0;
  bit  running = 1'b0;
  bit  ready_seen = 1'b1;
  bit  to_prev = 1'b0;
  bit  popped;
  int  wait_cyc = 0;
  int  exp_start = 0;
  int  start_cyc = 0;
  int  last_done = 0;
  int  err_cyc = -1;
  int  stall = 0;
  ev_t e;

  dbsao_lcu_scheduler #(
    .LCU_W_BITS(7),
    .LCU_H_BITS(7),
    .TO_BITS   (11),
    .TIMEOUT   (TIMEOUT)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .frame_start_i(frame_start_i),
    .pic_w_lcu_i  (pic_w_lcu_i),
    .pic_h_lcu_i  (pic_h_lcu_i),
    .lcu_ready_i  (lcu_ready_i),
    .dbsao_done_i (dbsao_done_i),
    .dbsao_start_o(dbsao_start_o),
    .lcu_x_o      (lcu_x_o),
    .lcu_y_o      (lcu_y_o),
    .busy_o       (busy_o),
    .frame_done_o (frame_done_o),
    .timeout_o    (timeout_o)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  function automatic void chk(string nm, int act, int exp_v);
    n_chk++;
    if (act == exp_v) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", nm, act, exp_v, cyc);
  endfunction

  // Engine model: done pulse eng_delay cycles after the start pulse.
  initial forever begin
    @(posedge clk);
    #1;
    if (!rst_n) begin
      eng_cnt  = 0;
      eng_done = 1'b0;
    end else begin
      eng_done = 1'b0;
      if (dbsao_start_o && !eng_never) begin
        eng_cnt = eng_delay;
      end else if (eng_cnt > 0) begin
        eng_cnt--;
        if (eng_cnt == 0) eng_done = 1'b1;
      end
    end
  end

  // Ready driver: fixed level or random.
  initial forever begin
    @(posedge clk);
    #3;
    if (rdy_mode == 1) lcu_ready_i = ($urandom_range(0, 3) != 0);
    else               lcu_ready_i = rdy_val;
  end

  // Monitor: pops expected events and checks protocol timing.
  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      chk("rst_start", int'(dbsao_start_o), 0);
      chk("rst_busy", int'(busy_o), 0);
      chk("rst_fdone", int'(frame_done_o), 0);
      chk("rst_timeout", int'(timeout_o), 0);
      chk("rst_x", int'(lcu_x_o), 0);
      chk("rst_y", int'(lcu_y_o), 0);
      exp_q.delete();
      m_busy = 0; m_to = 0; running = 0; ready_seen = 1;
      err_cyc = -1; to_prev = 0; stall = 0;
    end else begin
      popped = 0;
      chk("busy", int'(busy_o), int'(m_busy));
      chk("timeout_level", int'(timeout_o), int'(m_to));

      if (frame_start_i && !m_busy) begin
        m_busy = 1; m_to = 0; wait_cyc = cyc + 1; ready_seen = 0;
      end

      if (!ready_seen && cyc >= wait_cyc && lcu_ready_i) begin
        ready_seen = 1;
        exp_start  = cyc + 1;
      end

      if (dbsao_start_o) begin
        n_starts++;
        popped = 1;
        if (exp_q.size() == 0) chk("start_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("start_kind", K_START, e.kind);
          chk("start_x", int'(lcu_x_o), e.x);
          chk("start_y", int'(lcu_y_o), e.y);
        end
        chk("start_latency", cyc, ready_seen ? exp_start : -1);
        running = 1; start_cyc = cyc; ready_seen = 1;
      end else if (running && dbsao_done_i) begin
        running = 0; n_dones++; last_done = cyc;
        if (exp_q.size() > 0 && exp_q[0].kind == K_START) begin
          wait_cyc = cyc + 2; ready_seen = 0;
        end
      end else if (running && cyc == start_cyc + TIMEOUT) begin
        running = 0; err_cyc = cyc + 1;
      end

      if (cyc == err_cyc) begin
        m_busy = 0; m_to = 1; err_cyc = -1;
      end

      if (frame_done_o) begin
        popped = 1;
        if (exp_q.size() == 0) chk("fdone_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("fdone_kind", K_FDONE, e.kind);
        end
        chk("fdone_latency", cyc - last_done, 2);
        m_busy = 0;
      end

      if (timeout_o && !to_prev) begin
        popped = 1;
        if (exp_q.size() == 0) chk("timeout_unexpected", 1, 0);
        else begin
          e = exp_q.pop_front();
          chk("timeout_kind", K_TOUT, e.kind);
        end
      end
      to_prev = timeout_o;

      if (popped || exp_q.size() == 0) stall = 0;
      else stall++;
      if (stall > 3000) begin
        chk("stall_no_event", exp_q.size(), 0);
        exp_q.delete();
        stall = 0; running = 0; m_busy = 0;
      end
    end
  end

  // Issue one frame and push its expected event list.
  task automatic issue(int w, int h, int d, bit never);
    int  we = (w == 0) ? 1 : w;
    int  he = (h == 0) ? 1 : h;
    bit  to = never || (d > TIMEOUT);
    ev_t ev;
    @(posedge clk);
    #1;
    eng_delay     = d;
    eng_never     = never;
    frame_start_i = 1'b1;
    pic_w_lcu_i   = 7'(w);
    pic_h_lcu_i   = 7'(h);
    for (int yy = 0; yy < he; yy++) begin
      for (int xx = 0; xx < we; xx++) begin
        if (!to || (xx == 0 && yy == 0)) begin
          ev.kind = K_START; ev.x = xx; ev.y = yy;
          exp_q.push_back(ev);
        end
      end
    end
    ev.kind = to ? K_TOUT : K_FDONE; ev.x = 0; ev.y = 0;
    exp_q.push_back(ev);
    @(posedge clk);
    #1;
    frame_start_i = 1'b0;
  endtask

  task automatic wait_idle(int bound);
    int i = 0;
    while (exp_q.size() != 0 && i < bound) begin
      @(posedge clk);
      i++;
    end
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int base;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b1;

    // 2x2, ready high, nominal engine latency
    issue(2, 2, 1445, 0);
    wait_idle(12000);

    // zero dimensions behave as 1x1
    issue(0, 0, 7, 0);
    wait_idle(2000);

    // 3x1 with ready low for 20 cycles before LCU 1
    base = n_starts;
    issue(3, 1, 5, 0);
    for (int i = 0; i < 200 && n_starts < base + 1; i++) @(posedge clk);
    #1 rdy_val = 1'b0;
    base = n_dones;
    for (int i = 0; i < 200 && n_dones < base + 1; i++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1 rdy_val = 1'b1;
    wait_idle(2000);

    // engine never responds, then the next frame clears the flag
    issue(1, 1, 0, 1);
    wait_idle(4000);
    repeat (20) @(posedge clk);
    issue(1, 1, 3, 0);
    wait_idle(2000);

    // done on the last allowed watchdog cycle, and one cycle too late
    issue(1, 1, TIMEOUT, 0);
    wait_idle(4000);
    issue(1, 1, TIMEOUT + 1, 0);
    wait_idle(4000);

    // stray done in WAIT and frame_start mid-frame
    rdy_val = 1'b0;
    issue(2, 2, 4, 0);
    repeat (3) @(posedge clk);
    #1;
    stray_done = 1'b1; frame_start_i = 1'b1; pic_w_lcu_i = 7'd5; pic_h_lcu_i = 7'd5;
    @(posedge clk);
    #1;
    stray_done = 1'b0; frame_start_i = 1'b0;
    repeat (2) @(posedge clk);
    #1 rdy_val = 1'b1;
    repeat (12) @(posedge clk);
    #1 frame_start_i = 1'b1; pic_w_lcu_i = 7'd3; pic_h_lcu_i = 7'd3;
    @(posedge clk);
    #1 frame_start_i = 1'b0;
    wait_idle(2000);

    // reset during RUN of LCU 2, then a clean frame
    base = n_starts;
    issue(3, 2, 30, 0);
    for (int i = 0; i < 500 && n_starts < base + 3; i++) @(posedge clk);
    repeat (5) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    issue(2, 1, 4, 0);
    wait_idle(2000);

    // randomized frames with random ready
    rdy_mode = 1;
    for (int f = 0; f < 8; f++) begin
      issue(int'($urandom_range(0, 4)), int'($urandom_range(0, 3)),
            int'($urandom_range(1, 12)), 0);
      wait_idle(3000);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dbsao_lcu_scheduler.md
Name: dbsao_lcu_scheduler

Overview:
- Frame-level initiator for the deblocking/SAO engine controller; the engine itself is unchanged.
- Walks the picture in LCU raster order and issues one single-cycle start pulse per LCU.
- Waits for the engine's done pulse, enforces a watchdog timeout, then reports frame completion.
- Sits between the encoder top-level pipeline control and the DB/SAO engine.

Parameters:
- LCU_W_BITS, 7, width of LCU column count/index.
- LCU_H_BITS, 7, width of LCU row count/index.
- TO_BITS, 11, width of watchdog counter.
- TIMEOUT, 1500, cycles allowed in RUN before error (engine nominal ≈1445).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset.
- frame_start_i  in  1  pulse; begin a frame; honoured only in IDLE.
- pic_w_lcu_i  in  LCU_W_BITS  frame width in LCUs; latched on accepted frame_start_i.
- pic_h_lcu_i  in  LCU_H_BITS  frame height in LCUs; latched on accepted frame_start_i.
- lcu_ready_i  in  1  level; input data for the current LCU is available.
- dbsao_done_i  in  1  pulse from engine; current LCU finished.
- dbsao_start_o  out  1  one-cycle start pulse to engine.
- lcu_x_o  out  LCU_W_BITS  current LCU column.
- lcu_y_o  out  LCU_H_BITS  current LCU row.
- busy_o  out  1  high in every state except IDLE.
- frame_done_o  out  1  one-cycle pulse; frame completed normally.
- timeout_o  out  1  sticky watchdog error flag.

Behaviour:
- Reset is asynchronous, active-low (rst_n); clock is clk.
- All outputs reset to 0; state resets to IDLE; counters and latched dimensions reset to 0.
- State register encodings: IDLE, WAIT, START, RUN, NEXT, DONE, ERR.
- Outputs are decoded from registered state and counters only; no input-to-output combinational path.

State transitions:
- IDLE: frame_start_i=1 → WAIT.
  - Latch w = (pic_w_lcu_i==0 ? 1 : pic_w_lcu_i) and h likewise.
  - Set x=0, y=0; clear timeout_o.
- WAIT: lcu_ready_i=1 → START. Otherwise hold.
- START: dbsao_start_o=1 for exactly this cycle; clear watchdog; → RUN.
- RUN:
  - dbsao_done_i=1 → NEXT.
  - Else if watchdog == TIMEOUT-1 → ERR.
  - Else watchdog +1.
  - If done and timeout coincide, done wins.
- NEXT:
  - If x==w-1 and y==h-1 → DONE.
  - Else if x==w-1: x=0, y=y+1 → WAIT.
  - Else: x=x+1 → WAIT.
- DONE: frame_done_o=1 for this cycle → IDLE.
- ERR: set timeout_o=1 → IDLE. frame_done_o is not asserted.

Timing and event rules:
- Latency: lcu_ready_i sampled high in WAIT → dbsao_start_o high the next cycle.
- dbsao_done_i sampled in RUN → next LCU's start no earlier than 3 cycles later (NEXT, WAIT, START).
- dbsao_done_i outside RUN is ignored and has no side effects.
- frame_start_i outside IDLE is ignored; latched dimensions stay stable for the whole frame.
- lcu_x_o/lcu_y_o are valid from WAIT through NEXT and hold their last values in IDLE.
- Watchdog is TO_BITS wide and never wraps; TIMEOUT must be < 2^TO_BITS.
- Reset mid-frame: immediate return to IDLE with all outputs 0; no pulse is emitted.

Test Plan:
- 2x2 frame, lcu_ready_i tied high, done_i 1445 cycles after each start:
  - exactly 4 start pulses, with (x,y) = (0,0), (1,0), (0,1), (1,1);
  - one frame_done_o pulse 2 cycles after the 4th done;
  - timeout_o=0.
- pic_w_lcu_i=0, pic_h_lcu_i=0:
  - treated as 1x1, giving 1 start pulse and 1 frame_done_o;
  - busy_o high from the cycle after frame_start_i until DONE inclusive.
- 3x1 frame, lcu_ready_i low for 20 cycles before LCU 1:
  - start for LCU 1 occurs exactly 1 cycle after ready rises;
  - no extra pulses.
- Engine never responds:
  - ERR entered after 1500 RUN cycles; timeout_o=1 and stays high;
  - no frame_done_o; next frame_start_i clears timeout_o.
- done_i arrives on the cycle watchdog==1499 → treated as normal completion; timeout_o=0.
- Stray done_i in WAIT, plus frame_start_i mid-frame → both ignored; LCU sequence and count unchanged.
- rst_n asserted during RUN of LCU 2 → all outputs 0 asynchronously; after release, a new frame starts cleanly at (0,0).
